// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, widths and the per-pixel control bundle used by
// the scan generator and the output pipeline.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int CNT_W   = 10;
    localparam int COLOR_W = 3;
    localparam int DAC_W   = 8;

    typedef struct packed {
        logic visible;
        logic hs;
        logic vs;
    } scan_ctl_t;

    // Syncs are active-low, so the idle bundle keeps them high.
    localparam scan_ctl_t SCAN_CTL_IDLE = '{visible: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic [DAC_W-1:0] dac_expand(input logic bit_in);
        return {DAC_W{bit_in}};
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical scan counters and the combinational stage-0 decode of
// visible area and sync pulses; counters step only on pixel-enable cycles.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output scan_ctl_t        ctl,
    output logic             frame_end
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
    logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;
    logic             h_last, v_last;

    assign h_last = (h_cnt_reg == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt_reg == CNT_W'(V_TOTAL - 1));

    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (pix_en) begin
            if (h_last) begin
                h_cnt_next = '0;
                v_cnt_next = v_last ? '0 : v_cnt_reg + CNT_W'(1);
            end else begin
                h_cnt_next = h_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    assign h_cnt     = h_cnt_reg;
    assign v_cnt     = v_cnt_reg;
    assign frame_end = h_last & v_last;

    assign ctl.visible = (h_cnt_reg < CNT_W'(H_VISIBLE)) && (v_cnt_reg < CNT_W'(V_VISIBLE));
    assign ctl.hs      = !((h_cnt_reg >= CNT_W'(H_SYNC_START)) && (h_cnt_reg <= CNT_W'(H_SYNC_END)));
    assign ctl.vs      = !((v_cnt_reg >= CNT_W'(V_SYNC_START)) && (v_cnt_reg <= CNT_W'(V_SYNC_END)));

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan driver: divides CLOCK_50 into a pixel enable, requests pixel
// coordinates, and registers the responder colour with aligned syncs.
module vga_scan_driver
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    output logic               VGA_CLK,
    output logic [CNT_W-1:0]   x_vga,
    output logic [CNT_W-1:0]   y_vga,
    input  logic [COLOR_W-1:0] color_vga,
    output logic [DAC_W-1:0]   VGA_R,
    output logic [DAC_W-1:0]   VGA_G,
    output logic [DAC_W-1:0]   VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic               frame_start
);

    logic               pix_en_reg;
    logic [COLOR_W-1:0] color_reg;
    scan_ctl_t          ctl_reg;
    scan_ctl_t          ctl_stage0;
    logic               frame_end;
    logic               frame_start_reg;

    vga_sync_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_sync_gen (
        .clk       (CLOCK_50),
        .rst_n     (reset),
        .pix_en    (pix_en_reg),
        .h_cnt     (x_vga),
        .v_cnt     (y_vga),
        .ctl       (ctl_stage0),
        .frame_end (frame_end)
    );

    // Stage 1 captures the colour for the pixel being left together with its
    // decode, so the DAC lags the coordinate request by exactly one pixel.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pix_en_reg      <= 1'b0;
            color_reg       <= '0;
            ctl_reg         <= SCAN_CTL_IDLE;
            frame_start_reg <= 1'b0;
        end else begin
            pix_en_reg      <= ~pix_en_reg;
            frame_start_reg <= pix_en_reg & frame_end;
            if (pix_en_reg) begin
                color_reg <= color_vga;
                ctl_reg   <= ctl_stage0;
            end
        end
    end

    logic [COLOR_W-1:0][DAC_W-1:0] dac;

    for (genvar gi = 0; gi < COLOR_W; gi++) begin : g_dac
        assign dac[gi] = ctl_reg.visible ? dac_expand(color_reg[gi]) : '0;
    end

    assign VGA_R       = dac[2];
    assign VGA_G       = dac[1];
    assign VGA_B       = dac[0];
    assign VGA_CLK     = pix_en_reg;
    assign VGA_BLANK_N = ctl_reg.visible;
    assign VGA_HS      = ctl_reg.hs;
    assign VGA_VS      = ctl_reg.vs;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = frame_start_reg;

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameters V_FRONT=10, V_SYNC=2, V_BACK=33, vertical porch/sync lines.
REQ-007 The block SHALL have port CLOCK_50  in  1  sole clock, 50 MHz; all logic on its rising edge.
REQ-008 The block SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-009 The block SHALL have port VGA_CLK  out  1  25 MHz pixel clock, registered toggle.
REQ-010 The block SHALL have ports x_vga, y_vga  out  10 each  pixel-coordinate request to the game/pixel responder.
REQ-011 The block SHALL have port color_vga  in  3  responder colour {R,G,B}, valid one pixel period after request.
REQ-012 The block SHALL have ports VGA_R, VGA_G, VGA_B  out  8 each  DAC colour.
REQ-013 The block SHALL have ports VGA_HS, VGA_VS  out  1 each  active-low syncs.
REQ-014 The block SHALL have ports VGA_BLANK_N  out  1 (0 = blank); VGA_SYNC_N  out  1, constant 0.
REQ-015 The block SHALL have port frame_start  out  1  one-CLOCK_50-cycle pulse at frame wrap.

Function
REQ-016 pix_en SHALL toggle every CLOCK_50 cycle; VGA_CLK SHALL equal pix_en; all pixel state SHALL advance only on cycles with pix_en=1.
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), wrapping to 0.
REQ-018 v_cnt SHALL increment only on h_cnt wrap, count 0..V_TOTAL-1 (525), wrapping to 0 when h and v wrap together.
REQ-019 x_vga SHALL equal h_cnt and y_vga SHALL equal v_cnt (registered counters, no extra delay); values outside the visible area are don't-care for the responder.
REQ-020 Stage-0 signals SHALL be visible = (h_cnt<640 && v_cnt<480), hs = ~(656<=h_cnt<=751), vs = ~(490<=v_cnt<=491).
REQ-021 Stage 1 SHALL register color_vga, visible, hs, vs on each pix_en cycle, giving exactly one-pixel latency from coordinate to DAC output, with syncs aligned to colour.
REQ-022 VGA_R/G/B SHALL be each colour bit replicated 8 times (1 -> 8'hFF, 0 -> 8'h00) when registered visible=1, and 8'h00 otherwise.
REQ-023 VGA_BLANK_N SHALL equal registered visible; VGA_HS/VGA_VS SHALL equal registered hs/vs.
REQ-024 frame_start SHALL be 1 for exactly the CLOCK_50 cycle following the pix_en cycle in which (h_cnt,v_cnt) wraps from (799,524) to (0,0), and 0 otherwise.
REQ-025 Sync ranges SHALL be derived from parameters (sync starts at VISIBLE+FRONT, lasts SYNC); no literal 656/490 in RTL.

Reset
REQ-026 While reset=0: pix_en, VGA_CLK, h_cnt, v_cnt = 0; VGA_R/G/B = 0; VGA_BLANK_N = 0; VGA_HS = VGA_VS = 1; frame_start = 0; takes effect asynchronously.
REQ-027 Reset asserted mid-line or mid-frame SHALL abandon the frame; after release scanning SHALL restart at (0,0) with pix_en=0 on the first cycle.

Structure
REQ-028 Timing defaults, H_TOTAL/V_TOTAL and colour-width constants SHALL live in shared package vga_timing_pkg.
REQ-029 The h/v counters and stage-0 decode SHALL be sub-module vga_sync_gen; vga_scan_driver SHALL contain pix_en generation, output pipeline and frame_start.

Verification
REQ-030 Release reset, color_vga=3'b101 constant -> in visible area VGA_R=8'hFF, VGA_G=8'h00, VGA_B=8'hFF; during blanking all 8'h00 and VGA_BLANK_N=0.
REQ-031 Free-run -> VGA_CLK period 2 CLOCK_50 cycles; VGA_HS low for 192 CLOCK_50 cycles per 1600-cycle line; VGA_VS low for 2 lines per 525-line frame.
REQ-032 Drive color_vga = 3'b100 only when the previous x_vga was 10 -> VGA_R=8'hFF exactly in the pixel after x_vga=10, proving one-pixel latency.
REQ-033 Free-run from reset release -> first frame_start pulse 840000 CLOCK_50 cycles after release, width 1 cycle, then every 840000 cycles.
REQ-034 Assert reset with h_cnt=300, v_cnt=200 -> outputs immediately at REQ-026 values; after release x_vga=0, y_vga=0 and counting restarts.
REQ-035 Observe h_cnt 799 -> 0 with v_cnt 41 -> 42, and (799,524) -> (0,0) with v wrap and frame_start.
